// File: rtl/data_io_pkg.sv
// data_io_pkg
//   Shared constants for the ARM->FPGA file download path:
//   SPI_SS2 command codes, FILE_INFO payload byte offsets, the download
//   state type and a lane-mask helper used to build byte enables.
package data_io_pkg;

    localparam logic [7:0] DIO_FILE_TX     = 8'h53;
    localparam logic [7:0] DIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] DIO_FILE_INDEX  = 8'h55;
    localparam logic [7:0] DIO_FILE_INFO   = 8'h56;

    // FILE_INFO payload offsets (directory-entry layout)
    localparam logic [5:0] DIO_INFO_EXT_HI  = 6'h08;
    localparam logic [5:0] DIO_INFO_EXT_MID = 6'h09;
    localparam logic [5:0] DIO_INFO_EXT_LO  = 6'h0A;
    localparam logic [5:0] DIO_INFO_SIZE_B0 = 6'h1C;
    localparam logic [5:0] DIO_INFO_SIZE_B1 = 6'h1D;
    localparam logic [5:0] DIO_INFO_SIZE_B2 = 6'h1E;
    localparam logic [5:0] DIO_INFO_SIZE_B3 = 6'h1F;

    typedef enum logic [1:0] {
        DL_IDLE   = 2'd0,
        DL_ACTIVE = 2'd1,
        DL_ENDING = 2'd2
    } dl_state_t;

    // Byte enables for a word with n filled lanes (lanes 0..n-1).
    function automatic logic [3:0] lane_mask(input logic [2:0] n);
        return 4'((5'd1 << n) - 5'd1);
    endfunction

endpackage

// File: rtl/data_io_fifo.sv
// data_io_fifo
//   Synchronous word FIFO between the byte packer and the memory handshake.
//   A pop and a push in the same cycle on a full FIFO both succeed (the pop
//   frees the slot first). flush empties the FIFO and discards a same-cycle
//   push.
// Ports:
//   clk_sys, reset   clock, synchronous active-high reset
//   push, din        write request and data
//   pop              read request (ignored when empty)
//   flush            discard all contents
//   dout             head entry (valid when !empty)
//   full, empty      status
module data_io_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/data_io_wide.sv
// data_io_wide
//   MiST ARM->FPGA download engine. Oversamples the SPI_SS2 command channel
//   in clk_sys, packs FILE_TX_DAT bytes little-endian into DW-bit words,
//   queues them in data_io_fifo and hands them to memory with an
//   ioctl_wr/ioctl_ack handshake and per-lane byte enables.
//   Optional macro DATA_IO_FILEINFO_EN enables FILE_INFO capture of the
//   file extension and size; otherwise those outputs are constant 0.
// Ports:
//   clk_sys, reset                 clock, synchronous active-high reset
//   SPI_SCK, SPI_SS2, SPI_DI       raw asynchronous SPI lines
//   ioctl_download, ioctl_index    download active, menu index
//   ioctl_wr, ioctl_ack            word valid / sink accepts
//   ioctl_addr, ioctl_dout, ioctl_be   word byte address, data, lane enables
//   ioctl_fileext, ioctl_filesize  FILE_INFO fields
//   ioctl_overflow                 sticky word-dropped flag
//
// Download FSM:
//   state     | meaning
//   DL_IDLE   | no download; data bytes ignored
//   DL_ACTIVE | packing data bytes into words
//   DL_ENDING | end seen; waiting for the FIFO to drain
module data_io_wide
    import data_io_pkg::*;
#(
    parameter int DW         = 8,
    parameter int AW         = 25,
    parameter int START_ADDR = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            SPI_SCK,
    input  logic            SPI_SS2,
    input  logic            SPI_DI,
    output logic            ioctl_download,
    output logic [7:0]      ioctl_index,
    output logic            ioctl_wr,
    input  logic            ioctl_ack,
    output logic [AW-1:0]   ioctl_addr,
    output logic [DW-1:0]   ioctl_dout,
    output logic [DW/8-1:0] ioctl_be,
    output logic [23:0]     ioctl_fileext,
    output logic [31:0]     ioctl_filesize,
    output logic            ioctl_overflow
);

    localparam int BPW = DW / 8;
    localparam int FW  = DW + BPW;

    // SPI receive
    logic [1:0] sck_sync;
    logic [1:0] ss_sync;
    logic [1:0] di_sync;
    logic       sck_q;
    logic       sample;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       byte_stb;
    logic [7:0] byte_q;
    logic [7:0] byte_cmd;

    assign sample = sck_sync[1] & ~sck_q & ~ss_sync[1];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sck_sync  <= '0;
            ss_sync   <= 2'b11;
            di_sync   <= '0;
            sck_q     <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            byte_stb  <= 1'b0;
            byte_q    <= '0;
            byte_cmd  <= '0;
        end else begin
            sck_sync <= {sck_sync[0], SPI_SCK};
            ss_sync  <= {ss_sync[0], SPI_SS2};
            di_sync  <= {di_sync[0], SPI_DI};
            sck_q    <= sck_sync[1];
            byte_stb <= 1'b0;
            if (ss_sync[1]) begin
                bit_cnt   <= '0;
                cmd       <= '0;
                cmd_valid <= 1'b0;
            end else if (sample) begin
                shreg   <= {shreg[5:0], di_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (!cmd_valid) begin
                        cmd       <= {shreg, di_sync[1]};
                        cmd_valid <= 1'b1;
                    end else begin
                        // command travels with the byte so an SS2 rise
                        // right after the last bit cannot lose it
                        byte_stb <= 1'b1;
                        byte_q   <= {shreg, di_sync[1]};
                        byte_cmd <= cmd;
                    end
                end
            end
        end
    end

    // Packing and download control
    dl_state_t     state;
    logic [7:0]    index_reg;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_next;
    logic [2:0]    lane_cnt;
    logic          is_start;
    logic          is_end;
    logic          is_dat;
    logic          push;
    logic [FW-1:0] push_data;
    logic [FW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    assign is_start = byte_stb && (byte_cmd == DIO_FILE_TX) && byte_q[0];
    assign is_end   = byte_stb && (byte_cmd == DIO_FILE_TX) && !byte_q[0]
                      && (state == DL_ACTIVE);
    assign is_dat   = byte_stb && (byte_cmd == DIO_FILE_TX_DAT)
                      && (state == DL_ACTIVE);
    assign fifo_pop = ioctl_ack & ~fifo_empty;

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BPW; i++) begin
            if (lane_cnt == 3'(i)) acc_next[i*8 +: 8] = byte_q;
        end
        push      = 1'b0;
        push_data = '0;
        if (is_dat && lane_cnt == 3'(BPW-1)) begin
            push      = 1'b1;
            push_data = {{BPW{1'b1}}, acc_next};
        end else if (is_end && lane_cnt != 3'd0) begin
            // acc is zeroed after every push, so unfilled lanes read 0x00
            push      = 1'b1;
            push_data = {BPW'(lane_mask(lane_cnt)), acc};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= DL_IDLE;
            ioctl_download <= 1'b0;
            ioctl_index    <= '0;
            index_reg      <= '0;
            ioctl_addr     <= '0;
            ioctl_overflow <= 1'b0;
            acc            <= '0;
            lane_cnt       <= '0;
        end else begin
            if (byte_stb && byte_cmd == DIO_FILE_INDEX) index_reg <= byte_q;
            if (fifo_pop) ioctl_addr <= ioctl_addr + AW'(BPW);
            if (push && fifo_full && !fifo_pop) ioctl_overflow <= 1'b1;

            if (is_start) begin
                state          <= DL_ACTIVE;
                ioctl_download <= 1'b1;
                ioctl_index    <= index_reg;
                ioctl_addr     <= AW'(START_ADDR);
                ioctl_overflow <= 1'b0;
                acc            <= '0;
                lane_cnt       <= '0;
            end else begin
                case (state)
                    DL_ACTIVE: begin
                        if (is_dat) begin
                            if (lane_cnt == 3'(BPW-1)) begin
                                acc      <= '0;
                                lane_cnt <= '0;
                            end else begin
                                acc      <= acc_next;
                                lane_cnt <= lane_cnt + 3'd1;
                            end
                        end else if (is_end) begin
                            acc      <= '0;
                            lane_cnt <= '0;
                            state    <= DL_ENDING;
                        end
                    end
                    DL_ENDING: begin
                        // an empty FIFO also means ioctl_wr is low
                        if (fifo_empty) begin
                            state          <= DL_IDLE;
                            ioctl_download <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    data_io_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (push),
        .pop     (fifo_pop),
        .flush   (is_start),
        .din     (push_data),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The FIFO head is the presented word; ack pops it directly.
    assign ioctl_wr = ~fifo_empty;
    assign {ioctl_be, ioctl_dout} = fifo_empty ? '0 : fifo_dout;

`ifdef DATA_IO_FILEINFO_EN
    logic [5:0]  info_cnt;
    logic [23:0] fileext_r;
    logic [31:0] filesize_r;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            info_cnt   <= '0;
            fileext_r  <= '0;
            filesize_r <= '0;
        end else begin
            if (byte_stb && byte_cmd == DIO_FILE_INFO) begin
                case (info_cnt)
                    DIO_INFO_EXT_HI:  fileext_r[23:16]  <= byte_q;
                    DIO_INFO_EXT_MID: fileext_r[15:8]   <= byte_q;
                    DIO_INFO_EXT_LO:  fileext_r[7:0]    <= byte_q;
                    DIO_INFO_SIZE_B0: filesize_r[7:0]   <= byte_q;
                    DIO_INFO_SIZE_B1: filesize_r[15:8]  <= byte_q;
                    DIO_INFO_SIZE_B2: filesize_r[23:16] <= byte_q;
                    DIO_INFO_SIZE_B3: filesize_r[31:24] <= byte_q;
                    default: ;
                endcase
            end
            if (ss_sync[1])
                info_cnt <= '0;
            else if (byte_stb && byte_cmd == DIO_FILE_INFO)
                info_cnt <= info_cnt + 6'd1;
        end
    end

    assign ioctl_fileext  = fileext_r;
    assign ioctl_filesize = filesize_r;
`else
    assign ioctl_fileext  = '0;
    assign ioctl_filesize = '0;
`endif

endmodule

// File: tb/tb_data_io_wide.sv
module tb_data_io_wide;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic SPI_SCK = 1'b0;
    logic SPI_SS2 = 1'b1;
    logic SPI_DI  = 1'b0;

    always #5 clk_sys = ~clk_sys;

    // three instances share the SPI stream: DW=8, DW=32, DW=16/depth 4
    logic        dl8,  wr8,  ovf8;
    logic        dl32, wr32, ovf32, ack32;
    logic        dl16, wr16, ovf16, ack16;
    logic [7:0]  idx8, idx32, idx16;
    logic [24:0] addr8, addr32, addr16;
    logic [7:0]  dout8;
    logic [31:0] dout32;
    logic [15:0] dout16;
    logic        be8;
    logic [3:0]  be32;
    logic [1:0]  be16;
    logic [23:0] ext8, ext32, ext16;
    logic [31:0] size8, size32, size16;
    logic        ack8 = 1'b1;

    data_io_wide #(.DW(8)) u8 (
        .clk_sys(clk_sys), .reset(reset), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .ioctl_download(dl8), .ioctl_index(idx8), .ioctl_wr(wr8), .ioctl_ack(ack8),
        .ioctl_addr(addr8), .ioctl_dout(dout8), .ioctl_be(be8), .ioctl_fileext(ext8),
        .ioctl_filesize(size8), .ioctl_overflow(ovf8));

    data_io_wide #(.DW(32)) u32 (
        .clk_sys(clk_sys), .reset(reset), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .ioctl_download(dl32), .ioctl_index(idx32), .ioctl_wr(wr32), .ioctl_ack(ack32),
        .ioctl_addr(addr32), .ioctl_dout(dout32), .ioctl_be(be32), .ioctl_fileext(ext32),
        .ioctl_filesize(size32), .ioctl_overflow(ovf32));

    data_io_wide #(.DW(16), .FIFO_DEPTH(4)) u16 (
        .clk_sys(clk_sys), .reset(reset), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .ioctl_download(dl16), .ioctl_index(idx16), .ioctl_wr(wr16), .ioctl_ack(ack16),
        .ioctl_addr(addr16), .ioctl_dout(dout16), .ioctl_be(be16), .ioctl_fileext(ext16),
        .ioctl_filesize(size16), .ioctl_overflow(ovf16));

    typedef struct packed {
        logic [24:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } xfer_t;

    xfer_t      q8[$], q32[$], q16[$];
    logic [7:0] sent[$];
    int         vectors = 0;
    int         errors  = 0;
    int         mode32  = 1;   // 0 ack low, 1 ack high, 2 random
    int         mode16  = 1;

    // ack drivers, updated just after each rising edge
    initial begin
        ack32 = 1'b1;
        ack16 = 1'b1;
        forever begin
            @(posedge clk_sys);
            #1;
            ack32 = (mode32 == 2) ? 1'($urandom_range(0, 1)) : (mode32 == 1);
            ack16 = (mode16 == 2) ? 1'($urandom_range(0, 1)) : (mode16 == 1);
        end
    end

    // completed transfers, sampled mid-cycle
    always @(negedge clk_sys) begin
        if (wr8  && ack8)  q8.push_back({addr8, 32'(dout8), 4'(be8)});
        if (wr32 && ack32) q32.push_back({addr32, dout32, be32});
        if (wr16 && ack16) q16.push_back({addr16, 32'(dout16), 4'(be16)});
    end

    // reference model: byte stream chunked into little-endian words
    function automatic int m_count(int bpw);
        return (sent.size() + bpw - 1) / bpw;
    endfunction

    function automatic logic [31:0] m_data(int bpw, int w);
        logic [31:0] d = '0;
        for (int k = 0; k < bpw; k++)
            if (w*bpw + k < sent.size()) d[k*8 +: 8] = sent[w*bpw + k];
        return d;
    endfunction

    function automatic logic [3:0] m_be(int bpw, int w);
        logic [3:0] b = '0;
        for (int k = 0; k < bpw; k++)
            if (w*bpw + k < sent.size()) b[k] = 1'b1;
        return b;
    endfunction

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            SPI_DI = b[i];
            #40 SPI_SCK = 1'b1;
            #40 SPI_SCK = 1'b0;
        end
    endtask

    task automatic send_cmd1(input logic [7:0] c, input logic [7:0] b);
        SPI_SS2 = 1'b0; #50;
        spi_byte(c);
        spi_byte(b);
        #50 SPI_SS2 = 1'b1; #60;
    endtask

    task automatic send_data();
        SPI_SS2 = 1'b0; #50;
        spi_byte(8'h54);
        foreach (sent[i]) spi_byte(sent[i]);
        #50 SPI_SS2 = 1'b1; #60;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_sys);
            if (!dl8 && !dl32 && !dl16) begin ok = 1'b1; break; end
        end
    endtask

    task automatic download(input logic [7:0] idx);
        bit ok;
        send_cmd1(8'h55, idx);
        send_cmd1(8'h53, 8'h01);
        send_data();
        send_cmd1(8'h53, 8'h00);
        wait_idle(ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL download_end: ioctl_download still high after 3000 cycles, required 0"); end
    endtask

    task automatic clear_q();
        q8.delete(); q32.delete(); q16.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk_sys);
        @(negedge clk_sys);
        vectors++;
        if ({dl8, wr8, ovf8, idx8, addr8, dout8, be8} !== '0) begin
            errors++; $display("FAIL reset_u8: got %h required 0", {dl8, wr8, ovf8, idx8, addr8, dout8, be8});
        end
        vectors++;
        if ({dl32, wr32, ovf32, idx32, addr32, dout32, be32} !== '0) begin
            errors++; $display("FAIL reset_u32: got %h required 0", {dl32, wr32, ovf32, idx32, addr32, dout32, be32});
        end
        vectors++;
        if ({dl16, wr16, ovf16, idx16, addr16, dout16, be16, ext32, size32} !== '0) begin
            errors++; $display("FAIL reset_u16_info: got %h required 0", {dl16, wr16, ovf16, idx16, addr16, dout16, be16, ext32, size32});
        end
        reset = 1'b0;
        repeat (3) @(posedge clk_sys);
    endtask

    task automatic test_dw8();
        mode32 = 1; mode16 = 1;
        clear_q();
        sent = '{8'h11, 8'h22, 8'h33};
        download(8'h5A);
        vectors++;
        if (q8.size() != 3) begin errors++; $display("FAIL dw8_count: got %0d required 3", q8.size()); end
        for (int i = 0; i < q8.size() && i < 3; i++) begin
            vectors++;
            if (q8[i] !== {25'(i), m_data(1, i), 4'b0001}) begin
                errors++; $display("FAIL dw8_word%0d: got %h required %h", i, q8[i], {25'(i), m_data(1, i), 4'b0001});
            end
        end
        vectors++;
        if (idx8 !== 8'h5A) begin errors++; $display("FAIL dw8_index: got %h required 5a", idx8); end
        vectors++;
        if (q32.size() != 1 || q32[0] !== {25'd0, 32'h00332211, 4'b0111}) begin
            errors++; $display("FAIL dw8_u32_partial: got %0d words first %h required 1 word %h", q32.size(), q32[0], {25'd0, 32'h00332211, 4'b0111});
        end
    endtask

    task automatic test_dw32();
        mode32 = 2;
        clear_q();
        sent = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        download(8'h01);
        vectors++;
        if (q32.size() != 2) begin errors++; $display("FAIL dw32_count: got %0d required 2", q32.size()); end
        vectors++;
        if (q32[0] !== {25'd0, 32'h04030201, 4'b1111}) begin
            errors++; $display("FAIL dw32_word0: got %h required %h", q32[0], {25'd0, 32'h04030201, 4'b1111});
        end
        vectors++;
        if (q32[1] !== {25'd4, 32'h00000005, 4'b0001}) begin
            errors++; $display("FAIL dw32_word1: got %h required %h", q32[1], {25'd4, 32'h00000005, 4'b0001});
        end
    endtask

    task automatic test_overflow();
        bit ok;
        mode16 = 0; mode32 = 1;
        clear_q();
        sent.delete();
        for (int i = 0; i < 20; i++) sent.push_back(8'($urandom));
        send_cmd1(8'h55, 8'h03);
        send_cmd1(8'h53, 8'h01);
        send_data();
        repeat (20) @(negedge clk_sys);
        vectors++;
        if (q16.size() != 0 || wr16 !== 1'b1) begin
            errors++; $display("FAIL ovf_stall: got %0d xfers wr=%b required 0 xfers wr=1", q16.size(), wr16);
        end
        vectors++;
        if (ovf16 !== 1'b1 || ovf32 !== 1'b0) begin
            errors++; $display("FAIL ovf_flag: got u16=%b u32=%b required 1 0", ovf16, ovf32);
        end
        vectors++;
        if (dout16 !== {sent[1], sent[0]}) begin
            errors++; $display("FAIL ovf_head: got %h required %h", dout16, {sent[1], sent[0]});
        end
        mode16 = 1;
        repeat (20) @(negedge clk_sys);
        vectors++;
        if (q16.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d required 4", q16.size()); end
        for (int i = 0; i < q16.size() && i < 4; i++) begin
            vectors++;
            if (q16[i] !== {25'(2*i), m_data(2, i), 4'b0011}) begin
                errors++; $display("FAIL ovf_word%0d: got %h required %h", i, q16[i], {25'(2*i), m_data(2, i), 4'b0011});
            end
        end
        send_cmd1(8'h53, 8'h00);
        wait_idle(ok);
        vectors++;
        if (!ok || q16.size() != 4 || q32.size() != 5) begin
            errors++; $display("FAIL ovf_end: idle=%b u16 xfers=%0d u32 xfers=%0d required 1 4 5", ok, q16.size(), q32.size());
        end
    endtask

    task automatic test_restart();
        mode32 = 1; mode16 = 1;
        clear_q();
        send_cmd1(8'h53, 8'h01);
        sent = '{8'hA1, 8'hA2, 8'hA3};
        send_data();
        sent = '{8'h5E, 8'h6F, 8'h70, 8'h81};
        download(8'h07);
        vectors++;
        if (q32.size() != 1 || q32[0] !== {25'd0, 32'h81706F5E, 4'b1111}) begin
            errors++; $display("FAIL restart: got %0d words first %h required 1 word %h", q32.size(), q32[0], {25'd0, 32'h81706F5E, 4'b1111});
        end
        vectors++;
        if (ovf32 !== 1'b0 || ovf16 !== 1'b0) begin
            errors++; $display("FAIL restart_ovf_clear: got %b %b required 0 0", ovf32, ovf16);
        end
    endtask

    task automatic test_reset_mid();
        mode32 = 0; mode16 = 1;
        send_cmd1(8'h55, 8'h44);
        send_cmd1(8'h53, 8'h01);
        sent.delete();
        for (int i = 0; i < 8; i++) sent.push_back(8'($urandom));
        send_data();
        repeat (5) @(negedge clk_sys);
        vectors++;
        if (wr32 !== 1'b1 || dl32 !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got wr=%b dl=%b required 1 1", wr32, dl32);
        end
        clear_q();
        @(posedge clk_sys); #1 reset = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        vectors++;
        if ({dl32, wr32, ovf32, idx32, addr32, dout32, be32, dl8, wr8, dl16, wr16} !== '0) begin
            errors++; $display("FAIL mid_reset: got %h required 0", {dl32, wr32, ovf32, idx32, addr32, dout32, be32, dl8, wr8, dl16, wr16});
        end
        reset = 1'b0;
        mode32 = 1;
        repeat (30) @(negedge clk_sys);
        vectors++;
        if (q32.size() != 0 || dl32 !== 1'b0) begin
            errors++; $display("FAIL mid_after: got %0d xfers dl=%b required 0 0", q32.size(), dl32);
        end
    endtask

    task automatic test_random();
        xfer_t got[$];
        int    bpw;
        logic [7:0] idx;
        for (int it = 0; it < 4; it++) begin
            mode32 = 2; mode16 = 2;
            clear_q();
            sent.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) sent.push_back(8'($urandom));
            idx = 8'($urandom);
            download(idx);
            for (int inst = 0; inst < 3; inst++) begin
                bpw = (inst == 0) ? 1 : (inst == 1) ? 4 : 2;
                got = (inst == 0) ? q8 : (inst == 1) ? q32 : q16;
                vectors++;
                if (got.size() != m_count(bpw)) begin
                    errors++; $display("FAIL rand%0d_count_dw%0d: got %0d required %0d", it, bpw*8, got.size(), m_count(bpw));
                end
                for (int w = 0; w < got.size() && w < m_count(bpw); w++) begin
                    vectors++;
                    if (got[w] !== {25'(w*bpw), m_data(bpw, w), m_be(bpw, w)}) begin
                        errors++; $display("FAIL rand%0d_dw%0d_word%0d: got %h required %h", it, bpw*8, w, got[w], {25'(w*bpw), m_data(bpw, w), m_be(bpw, w)});
                    end
                end
            end
            vectors++;
            if (idx32 !== idx || idx16 !== idx) begin
                errors++; $display("FAIL rand%0d_index: got %h %h required %h", it, idx32, idx16, idx);
            end
        end
    endtask

    task automatic test_fileinfo();
        logic [7:0]  info [32];
        logic [23:0] exp_ext;
        logic [31:0] exp_size;
        for (int i = 0; i < 32; i++) info[i] = 8'($urandom);
        info[8]  = 8'h52; info[9]  = 8'h4F; info[10] = 8'h4D;
        info[28] = 8'h45; info[29] = 8'h23; info[30] = 8'h01; info[31] = 8'h00;
        SPI_SS2 = 1'b0; #50;
        spi_byte(8'h56);
        for (int i = 0; i < 32; i++) spi_byte(info[i]);
        #50 SPI_SS2 = 1'b1; #60;
        repeat (5) @(negedge clk_sys);
`ifdef DATA_IO_FILEINFO_EN
        exp_ext  = 24'h524F4D;
        exp_size = 32'h00012345;
`else
        exp_ext  = 24'h0;
        exp_size = 32'h0;
`endif
        vectors++;
        if (ext32 !== exp_ext || ext8 !== exp_ext) begin
            errors++; $display("FAIL fileext: got %h %h required %h", ext32, ext8, exp_ext);
        end
        vectors++;
        if (size32 !== exp_size || size16 !== exp_size) begin
            errors++; $display("FAIL filesize: got %h %h required %h", size32, size16, exp_size);
        end
    endtask

    initial begin
        test_reset();
        test_dw8();
        test_dw32();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_random();
        test_fileinfo();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
